// File: rtl/video_timing_480p.sv
// video_timing_480p: 640x480@60 raster timing generator gated by a synchronised PLL lock.
// Every output is registered and all of them describe the same pixel position in a given cycle.
module video_timing_480p #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       PCLK,
    input  logic       RESET_n,
    input  logic       PLOCK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       LINE_START,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       lock_meta_r;
    logic       lock_sync_r;
    logic       lock_s;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic [9:0] x_next_s;
    logic [9:0] y_next_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       de_next_s;
    logic       ls_next_s;
    logic       fs_next_s;

    // Two-flop synchroniser bringing the asynchronous PLL lock into the pixel domain
    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= PLOCK;
            lock_sync_r <= lock_meta_r;
        end
    end

    assign lock_s = lock_sync_r;

    // Decode the current counter position into next outputs and advance the raster
    always_comb begin
        h_next_s     = 10'd0;
        v_next_s     = 10'd0;
        x_next_s     = 10'd0;
        y_next_s     = 10'd0;
        hsync_next_s = ~HS_POL;
        vsync_next_s = ~VS_POL;
        de_next_s    = 1'b0;
        ls_next_s    = 1'b0;
        fs_next_s    = 1'b0;
        if (lock_s) begin
            x_next_s     = h_cnt_r;
            y_next_s     = v_cnt_r;
            de_next_s    = (h_cnt_r < H_ACT_W) && (v_cnt_r < V_ACT_W);
            hsync_next_s = ((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END)) ? HS_POL : ~HS_POL;
            vsync_next_s = ((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END)) ? VS_POL : ~VS_POL;
            ls_next_s    = (h_cnt_r == 10'd0);
            fs_next_s    = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
            if (h_cnt_r == H_LAST) begin
                h_next_s = 10'd0;
                if (v_cnt_r == V_LAST) begin
                    v_next_s = 10'd0;
                end else begin
                    v_next_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_next_s = h_cnt_r + 10'd1;
                v_next_s = v_cnt_r;
            end
        end else begin
            // Counters parked at zero so the next lock always starts a fresh frame
            h_next_s = 10'd0;
            v_next_s = 10'd0;
        end
    end

    // Raster counters and registered timing outputs
    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            h_cnt_r     <= 10'd0;
            v_cnt_r     <= 10'd0;
            X           <= 10'd0;
            Y           <= 10'd0;
            HSYNC       <= ~HS_POL;
            VSYNC       <= ~VS_POL;
            DE          <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            h_cnt_r     <= h_next_s;
            v_cnt_r     <= v_next_s;
            X           <= x_next_s;
            Y           <= y_next_s;
            HSYNC       <= hsync_next_s;
            VSYNC       <= vsync_next_s;
            DE          <= de_next_s;
            LINE_START  <= ls_next_s;
            FRAME_START <= fs_next_s;
        end
    end

endmodule

// File: tb/tb_video_timing_480p.sv
// Directed bench for video_timing_480p: full-size instance for lock/reset/line checks,
// plus a shrunken-geometry instance so whole frames fit in a short run.
module tb_video_timing_480p;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       plock;
    logic       hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
    logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } vec_t;

    localparam int NT = 14;
    vec_t tbl [NT];

    always #20 pclk = ~pclk;

    video_timing_480p dut (
        .PCLK(pclk), .RESET_n(rst_n), .PLOCK(plock),
        .HSYNC(hsync), .VSYNC(vsync), .DE(de), .X(x), .Y(y),
        .LINE_START(line_start), .FRAME_START(frame_start)
    );

    // Small raster: 15 pixels x 10 lines, HSYNC active-high on x=10..12, VSYNC active-low on y=7..8
    video_timing_480p #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_s (
        .PCLK(pclk), .RESET_n(rst_n), .PLOCK(plock),
        .HSYNC(s_hsync), .VSYNC(s_vsync), .DE(s_de), .X(s_x), .Y(s_y),
        .LINE_START(s_ls), .FRAME_START(s_fs)
    );

    function automatic logic [31:0] vpack(input logic hs, input logic vs, input logic d,
                                          input logic ls, input logic fs,
                                          input logic [9:0] xx, input logic [9:0] yy);
        return {7'd0, hs, vs, d, ls, fs, xx, yy};
    endfunction

    function automatic logic [31:0] dut_vec();
        return vpack(hsync, vsync, de, line_start, frame_start, x, y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, dut_vec(), vpack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int idx;
        int hs_low, de_hi, ls_c, fs_c;
        int de_c, vs_low, hs_high, fs2_at, pos_bad, vs_bad, hs_bad, de_bad, vs_edge_bad;
        logic prev_vs;
        logic found;

        tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{655,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{656,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{751,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{752,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1100, 10'd300, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1500, 10'd700, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1600, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{2700, 10'd300, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        plock = 1'b0;
        repeat (3) @(negedge pclk);
        check_idle("reset_idle");
        check("small_reset_idle", {27'd0, s_hsync, s_vsync, s_de, s_ls, s_fs},
              {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge pclk);
            if (dut_vec() !== vpack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0)) bad++;
        end
        check("unlocked_2000_nonidle_cycles", bad, 0);

        plock = 1'b1;
        @(negedge pclk);
        check_idle("lock_edge1_idle");
        @(negedge pclk);
        check_idle("lock_edge2_idle");
        @(negedge pclk);

        idx = 0; hs_low = 0; de_hi = 0; ls_c = 0; fs_c = 0;
        for (int n = 0; n <= 2700; n++) begin
            if (n > 0) @(negedge pclk);
            if (idx < NT && tbl[idx].n == n) begin
                check($sformatf("tbl_n%0d", n), dut_vec(),
                      vpack(tbl[idx].hs, tbl[idx].vs, tbl[idx].de, tbl[idx].ls, tbl[idx].fs,
                            tbl[idx].x, tbl[idx].y));
                idx++;
            end
            if (n < 2400) begin
                if (hsync === 1'b0) hs_low++;
                if (de === 1'b1) de_hi++;
                if (line_start === 1'b1) ls_c++;
                if (frame_start === 1'b1) fs_c++;
            end
        end
        check("table_entries_hit", idx, NT);
        check("hsync_low_3_lines", hs_low, 288);
        check("de_high_3_lines", de_hi, 1920);
        check("line_start_3_lines", ls_c, 3);
        check("frame_start_3_lines", fs_c, 1);

        // Lock lost while at (300,3)
        plock = 1'b0;
        @(negedge pclk);
        check("drop_edge1_running", dut_vec(), vpack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd301, 10'd3));
        @(negedge pclk);
        check("drop_edge2_running", dut_vec(), vpack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd302, 10'd3));
        @(negedge pclk);
        check_idle("drop_edge3_idle");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (dut_vec() !== vpack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0)) bad++;
        end
        check("dropped_hold_nonidle_cycles", bad, 0);

        plock = 1'b1;
        repeat (2) @(negedge pclk);
        check_idle("relock_edge2_idle");
        @(negedge pclk);
        check("relock_frame_start", dut_vec(), vpack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));

        repeat (50) @(negedge pclk);
        check("pre_reset_pos", dut_vec(), vpack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd50, 10'd0));
        #5;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset_immediate");
        repeat (3) @(negedge pclk);
        check_idle("reset_held_idle");
        rst_n = 1'b1;
        @(negedge pclk);
        check_idle("release_edge1_idle");
        @(negedge pclk);
        check_idle("release_edge2_idle");
        @(negedge pclk);
        check("release_frame_start", dut_vec(), vpack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));

        // Small-geometry instance: two whole frames
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge pclk);
            if (s_fs === 1'b1) found = 1'b1;
        end
        check("small_frame_start_seen", {31'd0, found}, 32'd1);

        de_c = 0; ls_c = 0; fs_c = 0; vs_low = 0; hs_high = 0; fs2_at = -1;
        pos_bad = 0; vs_bad = 0; hs_bad = 0; de_bad = 0; vs_edge_bad = 0;
        prev_vs = s_vsync;
        for (int m = 0; m < 300; m++) begin
            if (m > 0) @(negedge pclk);
            if (s_de === 1'b1) de_c++;
            if (s_ls === 1'b1) ls_c++;
            if (s_fs === 1'b1) fs_c++;
            if (s_fs === 1'b1 && m > 0 && fs2_at < 0) fs2_at = m;
            if (s_vsync === 1'b0) vs_low++;
            if (s_hsync === 1'b1) hs_high++;
            if (s_x !== 10'(m % 15) || s_y !== 10'((m / 15) % 10)) pos_bad++;
            if ((s_vsync === 1'b0) != (m % 150 >= 105 && m % 150 < 135)) vs_bad++;
            if ((s_hsync === 1'b1) != (m % 15 >= 10 && m % 15 <= 12)) hs_bad++;
            if ((s_de === 1'b1) != (m % 15 < 8 && m % 150 < 90)) de_bad++;
            if (m > 0 && s_vsync !== prev_vs && s_x !== 10'd0) vs_edge_bad++;
            prev_vs = s_vsync;
        end
        check("small_de_2_frames", de_c, 96);
        check("small_line_start_2_frames", ls_c, 20);
        check("small_frame_start_2_frames", fs_c, 2);
        check("small_frame_period", fs2_at, 150);
        check("small_vsync_active_2_frames", vs_low, 60);
        check("small_hsync_active_2_frames", hs_high, 60);
        check("small_position_errors", pos_bad, 0);
        check("small_vsync_window_errors", vs_bad, 0);
        check("small_hsync_window_errors", hs_bad, 0);
        check("small_de_window_errors", de_bad, 0);
        check("small_vsync_edge_not_at_x0", vs_edge_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
